// File: rtl/secded_counter.sv
// Up/down counter whose state lives in a SEC-DED Hamming codeword; single upsets are
// corrected on the fly and scrubbed, double upsets freeze the counter until a load.
module secded_counter #(
    parameter int WIDTH         = 16,
    parameter int ERR_CNT_W     = 8,
    parameter int SCRUB_ON_IDLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 up_down,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_value,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     count,
    output logic                 sec_err,
    output logic                 ded_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 wrap
);

    function automatic int calc_parity_bits(input int w);
        int p;
        p = 0;
        for (int k = 1; k < 31; k++) begin
            if (p == 0 && (1 << k) >= w + k + 1) p = k;
        end
        return p;
    endfunction

    localparam int P  = calc_parity_bits(WIDTH);
    localparam int N  = WIDTH + P;
    localparam int CW = N + 1;

    localparam logic [WIDTH-1:0]     ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]     ALL_ONES = {WIDTH{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

    // Hamming position (1-based) of data bit k: the k-th non-power-of-two position.
    function automatic int data_pos(input int k);
        int seen;
        int result;
        seen   = 0;
        result = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (seen == k) result = pos;
                seen++;
            end
        end
        return result;
    endfunction

    function automatic logic [CW-1:0] encode(input logic [WIDTH-1:0] data);
        logic [CW-1:0] code;
        logic          par;
        code = '0;
        for (int k = 0; k < WIDTH; k++) begin
            code[data_pos(k) - 1] = data[k];
        end
        for (int i = 0; i < P; i++) begin
            par = 1'b0;
            for (int pos = 1; pos <= N; pos++) begin
                if (pos[i]) par = par ^ code[pos - 1];
            end
            code[(1 << i) - 1] = par;
        end
        code[CW-1] = ^code[N-1:0];
        return code;
    endfunction

    logic [CW-1:0]        code_reg_q, code_reg_d;
    logic                 sec_err_q, sec_err_d;
    logic                 ded_err_q, ded_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 wrap_q, wrap_d;

    logic [P-1:0]         syndrome;
    logic                 overall;
    logic                 in_range;
    logic [CW-1:0]        corrected;
    logic                 sec_det;
    logic                 ded_det;
    logic [WIDTH-1:0]     count_step;

    // An odd overall parity whose syndrome points past the last position cannot be a
    // single upset, so it is treated as uncorrectable rather than silently ignored.
    always_comb begin
        syndrome = '0;
        for (int i = 0; i < P; i++) begin
            for (int pos = 1; pos <= N; pos++) begin
                if (pos[i]) syndrome[i] = syndrome[i] ^ code_reg_q[pos - 1];
            end
        end
        overall   = ^code_reg_q;
        in_range  = (syndrome != '0) && (int'(syndrome) <= N);
        corrected = code_reg_q;
        for (int pos = 1; pos <= N; pos++) begin
            if (overall && syndrome == pos[P-1:0]) corrected[pos - 1] = ~code_reg_q[pos - 1];
        end
        sec_det = overall && ((syndrome == '0) || in_range);
        ded_det = (!overall && syndrome != '0) || (overall && syndrome != '0 && !in_range);
        count   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            count[k] = corrected[data_pos(k) - 1];
        end
    end

    always_comb begin
        code_reg_d  = code_reg_q;
        sec_err_d   = sec_det;
        ded_err_d   = ded_err_q;
        err_count_d = err_count_q;
        wrap_d      = 1'b0;
        count_step  = up_down ? count + ONE : count - ONE;

        if (clear_err) begin
            ded_err_d   = 1'b0;
            err_count_d = '0;
        end
        if (ded_det) ded_err_d = 1'b1;
        if (sec_det) begin
            if (clear_err) err_count_d = ERR_ONE;
            else if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_ONE;
        end

        if (load) begin
            code_reg_d = encode(load_value);
        end else if (ded_det) begin
            code_reg_d = code_reg_q;
        end else if (enable) begin
            code_reg_d = encode(count_step);
            wrap_d     = up_down ? (count == ALL_ONES) : (count == '0);
        end else if (sec_det && SCRUB_ON_IDLE != 0) begin
            code_reg_d = encode(count);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_reg_q  <= encode('0);
            sec_err_q   <= 1'b0;
            ded_err_q   <= 1'b0;
            err_count_q <= '0;
            wrap_q      <= 1'b0;
        end else begin
            code_reg_q  <= code_reg_d;
            sec_err_q   <= sec_err_d;
            ded_err_q   <= ded_err_d;
            err_count_q <= err_count_d;
            wrap_q      <= wrap_d;
        end
    end

    assign sec_err   = sec_err_q;
    assign ded_err   = ded_err_q;
    assign err_count = err_count_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_secded_counter.sv
// Scoreboard bench for secded_counter: three instances (default, no idle scrub, 2-bit
// error counter) share stimulus; a data-level model predicts every registered output.
module tb_secded_counter;

    logic        clk = 1'b0;
    logic        reset, enable, up_down, load, clear_err;
    logic [15:0] load_value;

    logic [15:0] count_a, count_n, count_s;
    logic        sec_a, sec_n, sec_s;
    logic        ded_a, ded_n, ded_s;
    logic [7:0]  err_a, err_n;
    logic [1:0]  err_s;
    logic        wrap_a, wrap_n, wrap_s;

    always #5 clk = ~clk;

    secded_counter #(.WIDTH(16), .ERR_CNT_W(8), .SCRUB_ON_IDLE(1)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .clear_err(clear_err), .count(count_a),
        .sec_err(sec_a), .ded_err(ded_a), .err_count(err_a), .wrap(wrap_a));

    secded_counter #(.WIDTH(16), .ERR_CNT_W(8), .SCRUB_ON_IDLE(0)) dut_n (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .clear_err(clear_err), .count(count_n),
        .sec_err(sec_n), .ded_err(ded_n), .err_count(err_n), .wrap(wrap_n));

    secded_counter #(.WIDTH(16), .ERR_CNT_W(2), .SCRUB_ON_IDLE(1)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_value(load_value), .clear_err(clear_err), .count(count_s),
        .sec_err(sec_s), .ded_err(ded_s), .err_count(err_s), .wrap(wrap_s));

    typedef struct {
        logic [15:0] cnt;
        logic        sec;
        logic        sec_ns;
        logic        ded;
        int          err;
        int          err_ns;
        int          err_sat;
        logic        wrap;
        logic        chk_code;
        logic        chk_code_ns;
        logic [21:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // model state
    logic [15:0] m_count = '0;
    logic        m_dbl   = 1'b0;
    logic        m_pend  = 1'b0;
    logic        m_ded   = 1'b0;
    int          m_err = 0, m_err_ns = 0, m_err_sat = 0;

    // Hamming position of data bit k for a 16-bit word with 5 check bits.
    function automatic int tbDataPos(input int k);
        int seen;
        seen = 0;
        for (int pos = 1; pos <= 21; pos++) begin
            if (pos != 1 && pos != 2 && pos != 4 && pos != 8 && pos != 16) begin
                if (seen == k) return pos;
                seen++;
            end
        end
        return 0;
    endfunction

    function automatic logic [21:0] tbEncode(input logic [15:0] d);
        logic [21:0] c;
        c = '0;
        for (int k = 0; k < 16; k++) c[tbDataPos(k) - 1] = d[k];
        for (int i = 0; i < 5; i++) begin
            logic p;
            p = 1'b0;
            for (int pos = 1; pos <= 21; pos++) begin
                if (((pos >> i) & 1) == 1) p = p ^ c[pos - 1];
            end
            c[(1 << i) - 1] = p;
        end
        c[21] = ^c[20:0];
        return c;
    endfunction

    function automatic int bump(input int v, input logic hit, input logic clr, input int mx);
        if (hit) return clr ? 1 : ((v < mx) ? v + 1 : mx);
        return clr ? 0 : v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drives one cycle of inputs (optionally corrupting the stored codewords), predicts the
    // outputs after the next rising edge and queues the prediction for the monitor.
    task automatic applyStimulus(input logic rst, input logic en, input logic ud, input logic ld,
                                 input logic [15:0] lv, input logic clr, input int inj,
                                 input int pos_a, input int pos_b);
        exp_t        e;
        logic [21:0] bad;
        logic        sec, dedd, sec_ns, wr;
        @(negedge clk);
        reset = rst; enable = en; up_down = ud; load = ld; load_value = lv; clear_err = clr;
        if (inj != 0) begin
            bad = tbEncode(m_count);
            bad[pos_a - 1] = ~bad[pos_a - 1];
            if (inj == 2) bad[pos_b - 1] = ~bad[pos_b - 1];
            force dut_a.code_reg_q = bad;
            force dut_n.code_reg_q = bad;
            force dut_s.code_reg_q = bad;
            #1;
            release dut_a.code_reg_q;
            release dut_n.code_reg_q;
            release dut_s.code_reg_q;
            #1;
            checkOutput("count_during_upset_a", 32'(count_a), 32'(m_count));
            checkOutput("count_during_upset_n", 32'(count_n), 32'(m_count));
            checkOutput("count_during_upset_s", 32'(count_s), 32'(m_count));
        end
        wr = 1'b0;
        if (rst) begin
            m_count = '0; m_dbl = 1'b0; m_pend = 1'b0; m_ded = 1'b0;
            m_err = 0; m_err_ns = 0; m_err_sat = 0;
            sec = 1'b0; sec_ns = 1'b0;
        end else begin
            sec    = (inj == 1);
            dedd   = (inj == 2) || m_dbl;
            sec_ns = (inj == 1) || m_pend;
            m_ded     = (clr ? 1'b0 : m_ded) | dedd;
            m_err     = bump(m_err, sec, clr, 255);
            m_err_sat = bump(m_err_sat, sec, clr, 3);
            m_err_ns  = bump(m_err_ns, sec_ns, clr, 255);
            if (ld) begin
                m_count = lv; m_dbl = 1'b0; m_pend = 1'b0;
            end else if (dedd) begin
                m_dbl = 1'b1;
            end else if (en) begin
                if (ud) begin
                    wr = (m_count == 16'hFFFF);
                    m_count = m_count + 16'd1;
                end else begin
                    wr = (m_count == 16'h0000);
                    m_count = m_count - 16'd1;
                end
                m_pend = 1'b0;
            end else if (inj == 1) begin
                m_pend = 1'b1;
            end
        end
        e.cnt = m_count; e.sec = sec; e.sec_ns = sec_ns; e.ded = m_ded;
        e.err = m_err; e.err_ns = m_err_ns; e.err_sat = m_err_sat; e.wrap = wr;
        e.chk_code = !m_dbl; e.chk_code_ns = !m_dbl && !m_pend; e.code = tbEncode(m_count);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 0, 0, 0);
    endtask

    task automatic step(input logic ud);
        applyStimulus(1'b0, 1'b1, ud, 1'b0, 16'h0, 1'b0, 0, 0, 0);
    endtask

    task automatic loadValue(input logic [15:0] v);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, v, 1'b0, 0, 0, 0);
    endtask

    // Monitor: pops one prediction per rising edge, just after the edge settles.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("count_a", 32'(count_a), 32'(e.cnt));
                checkOutput("count_n", 32'(count_n), 32'(e.cnt));
                checkOutput("count_s", 32'(count_s), 32'(e.cnt));
                checkOutput("sec_a", 32'(sec_a), 32'(e.sec));
                checkOutput("sec_n", 32'(sec_n), 32'(e.sec_ns));
                checkOutput("sec_s", 32'(sec_s), 32'(e.sec));
                checkOutput("ded_a", 32'(ded_a), 32'(e.ded));
                checkOutput("ded_n", 32'(ded_n), 32'(e.ded));
                checkOutput("ded_s", 32'(ded_s), 32'(e.ded));
                checkOutput("err_a", 32'(err_a), 32'(e.err));
                checkOutput("err_n", 32'(err_n), 32'(e.err_ns));
                checkOutput("err_s", 32'(err_s), 32'(e.err_sat));
                checkOutput("wrap_a", 32'(wrap_a), 32'(e.wrap));
                checkOutput("wrap_n", 32'(wrap_n), 32'(e.wrap));
                checkOutput("wrap_s", 32'(wrap_s), 32'(e.wrap));
                if (e.chk_code) checkOutput("code_a", 32'(dut_a.code_reg_q), 32'(e.code));
                if (e.chk_code_ns) checkOutput("code_n", 32'(dut_n.code_reg_q), 32'(e.code));
            end
        end
    end

    initial begin
        logic r_en, r_ud;
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0;
        load_value = '0; clear_err = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 45; i++) step(1'b1);

        // Single upset on data bit 3 while idle; the no-scrub copy keeps reporting it.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1, tbDataPos(3), 0);
        idle(3);
        step(1'b1);
        idle(1);

        // Upset on the overall parity bit only.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1, 22, 0);
        idle(1);
        step(1'b1);

        // Three more single upsets drive the 2-bit counter into saturation.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1, tbDataPos(0), 0);
        step(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1, 4, 0);
        step(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1, tbDataPos(15), 0);
        idle(1);

        // A sixth upset together with clear_err leaves the count at one.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 1, tbDataPos(7), 0);
        step(1'b1);

        // Double upset on two check bits while counting: counter freezes, ded_err sticks.
        loadValue(16'h0010);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 2, 1, 2);
        step(1'b1);
        step(1'b1);
        loadValue(16'h1234);
        step(1'b1);
        step(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 0, 0, 0);
        idle(1);

        // Wrap in both directions; a load never wraps.
        loadValue(16'hFFFF);
        step(1'b1);
        step(1'b0);
        loadValue(16'h0000);
        idle(1);
        step(1'b0);
        step(1'b1);

        // Reset in the same cycle as an upset discards it.
        step(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1, tbDataPos(2), 0);
        step(1'b1);
        step(1'b1);

        for (int i = 0; i < 24; i++) begin
            r_en = 1'($urandom_range(0, 1));
            r_ud = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, r_en, r_ud, 1'b0, 16'h0, 1'b0, 0, 0, 0);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
